// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP receive path.
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int BYTE_W        = 8;
  localparam int PORT_W        = 16;
  localparam int LEN_W         = 16;
  localparam int CNT_W         = 16;
  localparam int STAT_W        = 32;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LATCH,
    CHECK,
    PAYLOAD,
    DROP
  } rx_state_t;

endpackage

// File: rtl/udp_header_parser.sv
// Collects the 8-byte UDP header (big-endian) and publishes the port/length
// fields when latch_outputs is pulsed. The checksum bytes are consumed but ignored.
module udp_header_parser
  import udp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              parse_enable,
  input  logic              ready_out,
  input  logic              latch_outputs,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              header_done,
  output logic [PORT_W-1:0] src_port,
  output logic [PORT_W-1:0] dst_port,
  output logic [LEN_W-1:0]  length
);

  localparam int IDX_W = $clog2(UDP_HDR_BYTES);

  logic [IDX_W-1:0]  byte_idx;
  logic [PORT_W-1:0] src_q;
  logic [PORT_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              take;

  assign take        = parse_enable && ready_out && s_valid;
  assign header_done = take && (byte_idx == IDX_W'(UDP_HDR_BYTES - 1));

  // Index restarts whenever the controller leaves HEADER, so every frame starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      src_port <= '0;
      dst_port <= '0;
      length   <= '0;
    end else begin
      if (!parse_enable) begin
        byte_idx <= '0;
      end else if (take) begin
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          IDX_W'(0): src_q[15:8] <= s_data;
          IDX_W'(1): src_q[7:0]  <= s_data;
          IDX_W'(2): dst_q[15:8] <= s_data;
          IDX_W'(3): dst_q[7:0]  <= s_data;
          IDX_W'(4): len_q[15:8] <= s_data;
          IDX_W'(5): len_q[7:0]  <= s_data;
          default:   ;
        endcase
      end
      if (latch_outputs) begin
        src_port <= src_q;
        dst_port <= dst_q;
        length   <= len_q;
      end
    end
  end

endmodule

// File: rtl/udp_rx_ctrl.sv
// UDP receive controller: parses the header, filters on destination port and
// streams the payload. Optional frame counters are enabled with UDP_RX_STATS_EN.
module udp_rx_ctrl
  import udp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  input  logic [PORT_W-1:0] target_port,
  output logic [PORT_W-1:0] src_port,
  output logic [PORT_W-1:0] dst_port,
  output logic [LEN_W-1:0]  length,
  output logic              hdr_valid,
  output logic              drop_pulse,
  output logic              err_pulse,
  output logic              busy
`ifdef UDP_RX_STATS_EN
  ,
  output logic [STAT_W-1:0] frames_ok,
  output logic [STAT_W-1:0] frames_dropped,
  output logic [STAT_W-1:0] frames_err
`endif
);

  rx_state_t        state;
  rx_state_t        tail_state;
  logic [CNT_W-1:0] pay_cnt;
  logic             last_seen;
  logic             parse_enable;
  logic             latch_outputs;
  logic             header_done;
  logic             pay_hs;
  logic             pay_final;

  assign parse_enable  = (state == HEADER);
  assign latch_outputs = (state == LATCH);
  assign pay_hs        = (state == PAYLOAD) && s_valid && m_ready;
  assign pay_final     = (pay_cnt == CNT_W'(1));

  // A frame whose s_last arrived with the header has nothing left to drain.
  assign tail_state = last_seen ? IDLE : DROP;

  udp_header_parser u_parser (
    .clk          (clk),
    .rst_n        (rst_n),
    .parse_enable (parse_enable),
    .ready_out    (parse_enable),
    .latch_outputs(latch_outputs),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .header_done  (header_done),
    .src_port     (src_port),
    .dst_port     (dst_port),
    .length       (length)
  );

  always_comb begin
    s_ready = 1'b0;
    case (state)
      HEADER, DROP: s_ready = 1'b1;
      PAYLOAD:      s_ready = m_ready;
      default:      s_ready = 1'b0;
    endcase
  end

  assign m_valid = (state == PAYLOAD) && s_valid;
  assign m_data  = (state == PAYLOAD) ? s_data : '0;
  assign m_last  = m_valid && (pay_final || s_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pay_cnt    <= '0;
      last_seen  <= 1'b0;
      hdr_valid  <= 1'b0;
      drop_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      hdr_valid  <= 1'b0;
      drop_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state <= HEADER;
            busy  <= 1'b1;
          end
        end
        HEADER: begin
          if (header_done) begin
            state     <= LATCH;
            last_seen <= s_last;
          end else if (s_valid && s_last) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        LATCH: state <= CHECK;
        // Short length wins over a port mismatch so malformed frames count as errors.
        CHECK: begin
          if (length < LEN_W'(UDP_HDR_BYTES)) begin
            err_pulse <= 1'b1;
            state     <= tail_state;
            busy      <= !last_seen;
          end else if (dst_port != target_port) begin
            drop_pulse <= 1'b1;
            state      <= tail_state;
            busy       <= !last_seen;
          end else begin
            hdr_valid <= 1'b1;
            if (length == LEN_W'(UDP_HDR_BYTES)) begin
              state <= tail_state;
              busy  <= !last_seen;
            end else begin
              pay_cnt <= length - LEN_W'(UDP_HDR_BYTES);
              state   <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pay_hs) begin
            pay_cnt <= pay_cnt - 1'b1;
            if (pay_final) begin
              state <= s_last ? IDLE : DROP;
              busy  <= !s_last;
            end else if (s_last) begin
              err_pulse <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        DROP: begin
          if (s_valid && s_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UDP_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ok      <= '0;
      frames_dropped <= '0;
      frames_err     <= '0;
    end else begin
      if (hdr_valid)  frames_ok      <= frames_ok + 1'b1;
      if (drop_pulse) frames_dropped <= frames_dropped + 1'b1;
      if (err_pulse)  frames_err     <= frames_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// Directed, table-driven bench for udp_rx_ctrl; each row is one clock of stimulus
// with hand-derived expected outputs. Stats checks compile only with UDP_RX_STATS_EN.
module tb_udp_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready;
  logic [15:0] target_port, src_port, dst_port, length;
  logic        hdr_valid, drop_pulse, err_pulse, busy;
`ifdef UDP_RX_STATS_EN
  logic [31:0] frames_ok, frames_dropped, frames_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  udp_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .target_port(target_port),
    .src_port(src_port), .dst_port(dst_port), .length(length),
    .hdr_valid(hdr_valid), .drop_pulse(drop_pulse), .err_pulse(err_pulse), .busy(busy)
`ifdef UDP_RX_STATS_EN
    , .frames_ok(frames_ok), .frames_dropped(frames_dropped), .frames_err(frames_err)
`endif
  );

  typedef struct {
    logic [7:0]  sd;
    logic        sv, sl, mr;
    logic [15:0] tp;
    logic        e_srdy, e_mv;
    logic [7:0]  e_md;
    logic        e_ml, e_hv, e_dp, e_ep, e_busy;
    string       tag;
  } vec_t;

  vec_t        vecs[$];
  string       cur_tag;
  logic [15:0] cur_target;

  function automatic logic [7:0] hdrByte(input logic [15:0] src, input logic [15:0] dst,
                                         input logic [15:0] len, input int i);
    logic [63:0] h;
    h = {src, dst, len, 16'h0000};
    return h[63-8*i -: 8];
  endfunction

  task automatic addVec(input logic [7:0] sd, input logic sv, input logic sl, input logic mr,
                        input logic srdy, input logic mv, input logic [7:0] md, input logic ml,
                        input logic hv, input logic dp, input logic ep, input logic bsy);
    vec_t v;
    v.sd = sd; v.sv = sv; v.sl = sl; v.mr = mr; v.tp = cur_target;
    v.e_srdy = srdy; v.e_mv = mv; v.e_md = md; v.e_ml = ml;
    v.e_hv = hv; v.e_dp = dp; v.e_ep = ep; v.e_busy = bsy;
    v.tag = cur_tag;
    vecs.push_back(v);
  endtask

  // IDLE row, eight HEADER rows, then the LATCH and CHECK rows (nothing accepted there).
  task automatic addFrameHeader(input logic [15:0] src, input logic [15:0] dst,
                                input logic [15:0] len, input logic last8,
                                input logic [7:0] nd, input logic nv);
    addVec(hdrByte(src, dst, len, 0), 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      addVec(hdrByte(src, dst, len, i), 1, (i == 7) && last8, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    addVec(nd, nv, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    addVec(nd, nv, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic addIdle(input logic hv, input logic dp, input logic ep);
    addVec(8'h00, 0, 0, 1, 0, 0, 8'h00, 0, hv, dp, ep, 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    s_data      = v.sd;
    s_valid     = v.sv;
    s_last      = v.sl;
    m_ready     = v.mr;
    target_port = v.tp;
    #1;
  endtask

  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s[%0d].s_ready",    vecs[i].tag, i), 32'(s_ready),    32'(vecs[i].e_srdy));
      checkOutput($sformatf("%s[%0d].m_valid",    vecs[i].tag, i), 32'(m_valid),    32'(vecs[i].e_mv));
      checkOutput($sformatf("%s[%0d].m_data",     vecs[i].tag, i), 32'(m_data),     32'(vecs[i].e_md));
      checkOutput($sformatf("%s[%0d].m_last",     vecs[i].tag, i), 32'(m_last),     32'(vecs[i].e_ml));
      checkOutput($sformatf("%s[%0d].hdr_valid",  vecs[i].tag, i), 32'(hdr_valid),  32'(vecs[i].e_hv));
      checkOutput($sformatf("%s[%0d].drop_pulse", vecs[i].tag, i), 32'(drop_pulse), 32'(vecs[i].e_dp));
      checkOutput($sformatf("%s[%0d].err_pulse",  vecs[i].tag, i), 32'(err_pulse),  32'(vecs[i].e_ep));
      checkOutput($sformatf("%s[%0d].busy",       vecs[i].tag, i), 32'(busy),       32'(vecs[i].e_busy));
    end
    vecs.delete();
  endtask

  // Good frame: 12-byte length, four payload bytes AA..DD, s_last on DD.
  task automatic buildGoodFrame(input string tag);
    cur_tag = tag; cur_target = 16'h1234;
    addFrameHeader(16'h5000, 16'h1234, 16'h000C, 0, 8'hAA, 1);
    addVec(8'hAA, 1, 0, 1, 1, 1, 8'hAA, 0, 1, 0, 0, 1);
    addVec(8'hBB, 1, 0, 1, 1, 1, 8'hBB, 0, 0, 0, 0, 1);
    addVec(8'hCC, 1, 0, 1, 1, 1, 8'hCC, 0, 0, 0, 0, 1);
    addVec(8'hDD, 1, 1, 1, 1, 1, 8'hDD, 1, 0, 0, 0, 1);
    addIdle(0, 0, 0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".m_valid"},    32'(m_valid),    32'd0);
    checkOutput({tag, ".s_ready"},    32'(s_ready),    32'd0);
    checkOutput({tag, ".m_data"},     32'(m_data),     32'd0);
    checkOutput({tag, ".m_last"},     32'(m_last),     32'd0);
    checkOutput({tag, ".busy"},       32'(busy),       32'd0);
    checkOutput({tag, ".hdr_valid"},  32'(hdr_valid),  32'd0);
    checkOutput({tag, ".drop_pulse"}, 32'(drop_pulse), 32'd0);
    checkOutput({tag, ".err_pulse"},  32'(err_pulse),  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; target_port = 16'h1234;
    repeat (3) @(negedge clk);
    #1;
    checkQuiet("reset");
    checkOutput("reset.src_port", 32'(src_port), 32'd0);
    checkOutput("reset.dst_port", 32'(dst_port), 32'd0);
    checkOutput("reset.length",   32'(length),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    buildGoodFrame("good");
    runVectors();
    checkOutput("good.src_port", 32'(src_port), 32'h5000);
    checkOutput("good.dst_port", 32'(dst_port), 32'h1234);
    checkOutput("good.length",   32'(length),   32'h000C);

    // Port mismatch: the whole frame is swallowed with no output beats.
    cur_tag = "filt"; cur_target = 16'h4321;
    addFrameHeader(16'h5000, 16'h1234, 16'h000C, 0, 8'hAA, 1);
    addVec(8'hAA, 1, 0, 1, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    addVec(8'hBB, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    addVec(8'hCC, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    addVec(8'hDD, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    addIdle(0, 0, 0);
    runVectors();

    // Truncated payload: s_last on the second of four payload bytes.
    cur_tag = "trunc"; cur_target = 16'h1234;
    addFrameHeader(16'h5000, 16'h1234, 16'h000C, 0, 8'hAA, 1);
    addVec(8'hAA, 1, 0, 1, 1, 1, 8'hAA, 0, 1, 0, 0, 1);
    addVec(8'hBB, 1, 1, 1, 1, 1, 8'hBB, 1, 0, 0, 0, 1);
    addIdle(0, 0, 1);
    addIdle(0, 0, 0);
    runVectors();

    // Back-pressure: m_ready low for three cycles while BB is presented.
    cur_tag = "stall"; cur_target = 16'h1234;
    addFrameHeader(16'h5000, 16'h1234, 16'h000C, 0, 8'hAA, 1);
    addVec(8'hAA, 1, 0, 1, 1, 1, 8'hAA, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      addVec(8'hBB, 1, 0, 0, 0, 1, 8'hBB, 0, 0, 0, 0, 1);
    addVec(8'hBB, 1, 0, 1, 1, 1, 8'hBB, 0, 0, 0, 0, 1);
    addVec(8'hCC, 1, 0, 1, 1, 1, 8'hCC, 0, 0, 0, 0, 1);
    addVec(8'hDD, 1, 1, 1, 1, 1, 8'hDD, 1, 0, 0, 0, 1);
    addIdle(0, 0, 0);
    runVectors();

    // Length field below header size, frame ends on header byte 8.
    cur_tag = "shortlen"; cur_target = 16'h1234;
    addFrameHeader(16'h5000, 16'h1234, 16'h0004, 1, 8'h00, 0);
    addIdle(0, 0, 1);
    addIdle(0, 0, 0);
    runVectors();

    // Frame ends inside the header (5 bytes).
    cur_tag = "shorthdr"; cur_target = 16'h1234;
    addVec(hdrByte(16'h5000, 16'h1234, 16'h000C, 0), 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(hdrByte(16'h5000, 16'h1234, 16'h000C, i), 1, i == 4, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    addIdle(0, 0, 1);
    addIdle(0, 0, 0);
    runVectors();

    // Header-only frame with length exactly 8.
    cur_tag = "hdronly"; cur_target = 16'h00AB;
    addFrameHeader(16'h0102, 16'h00AB, 16'h0008, 1, 8'h00, 0);
    addIdle(1, 0, 0);
    addIdle(0, 0, 0);
    runVectors();
    checkOutput("hdronly.src_port", 32'(src_port), 32'h0102);
    checkOutput("hdronly.length",   32'(length),   32'h0008);

`ifdef UDP_RX_STATS_EN
    checkOutput("stats.frames_ok",      frames_ok,      32'd4);
    checkOutput("stats.frames_dropped", frames_dropped, 32'd1);
    checkOutput("stats.frames_err",     frames_err,     32'd3);
`endif

    // Reset while streaming payload, then a fresh frame must parse normally.
    cur_tag = "rstpre"; cur_target = 16'h1234;
    addFrameHeader(16'h5000, 16'h1234, 16'h000C, 0, 8'hAA, 1);
    addVec(8'hAA, 1, 0, 1, 1, 1, 8'hAA, 0, 1, 0, 0, 1);
    runVectors();
    @(negedge clk);
    s_data = 8'hBB; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkQuiet("rst_now");
    repeat (2) @(negedge clk);
    #1;
    checkQuiet("rst_hold");
    checkOutput("rst_hold.length", 32'(length), 32'd0);
`ifdef UDP_RX_STATS_EN
    checkOutput("rst_hold.frames_ok", frames_ok, 32'd0);
`endif
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkQuiet("rst_release");

    buildGoodFrame("postrst");
    runVectors();
    checkOutput("postrst.dst_port", 32'(dst_port), 32'h1234);

`ifdef UDP_RX_STATS_EN
    checkOutput("stats_final.frames_ok",      frames_ok,      32'd1);
    checkOutput("stats_final.frames_dropped", frames_dropped, 32'd0);
    checkOutput("stats_final.frames_err",     frames_err,     32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
